goertzel_dtmf_decide: RTL and testbench

GOERTZEL_DTMF_DECIDE -- requirements
Module: goertzel_dtmf_decide

---
 rtl/goertzel_dtmf_decide_if.sv | 28 ++
 rtl/goertzel_dtmf_decide.sv | 168 ++++++++++++++++
 tb/tb_goertzel_dtmf_decide.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/goertzel_dtmf_decide_if.sv
// Bundles the magnitude stream, the per-frame configuration and the decision
// outputs of the DTMF decision stage.
interface goertzel_dtmf_decide_if #(
  parameter int unsigned MW = 32
);
  logic          mag_valid;
  logic [2:0]    mag_idx;
  logic [MW-1:0] mag_i;
  logic [MW-1:0] thresh_i;
  logic [2:0]    twist_sh_i;
  logic          flush;
  logic          busy;
  logic          drop;
  logic          frame_done;
  logic          det;
  logic          key_valid;
  logic [3:0]    key_code;

  modport master (
    output mag_valid, mag_idx, mag_i, thresh_i, twist_sh_i, flush,
    input  busy, drop, frame_done, det, key_valid, key_code
  );

  modport slave (
    input  mag_valid, mag_idx, mag_i, thresh_i, twist_sh_i, flush,
    output busy, drop, frame_done, det, key_valid, key_code
  );
endinterface

// File: rtl/goertzel_dtmf_decide.sv
// DTMF decision stage: collects eight Goertzel bin magnitudes per frame, picks the
// strongest row/column tone, applies threshold and twist checks, and debounces keys.
module goertzel_dtmf_decide #(
  parameter int unsigned DEB = 2,
  parameter int unsigned MW  = 32
) (
  input logic                 clk,
  input logic                 rstn,
  goertzel_dtmf_decide_if.slave bus
);

  typedef enum logic [1:0] {COLLECT, EVAL, REPORT} state_e;

  localparam logic [3:0] DEB_C = 4'(DEB);

  state_e        state_q, state_d;
  logic [7:0]    mask_q, mask_d;
  logic [MW-1:0] mag_q [8];
  logic          cap;

  logic [3:0]    cand_q, cand_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          drop_q, drop_d;
  logic          frame_done_q, frame_done_d;
  logic          det_q, det_d;
  logic          key_valid_q, key_valid_d;

  logic [MW-1:0] rmax, cmax;
  logic [1:0]    ri, ci;
  logic [MW+7:0] hi_w, lo_sh_w;
  logic          twist_ok, det_w;
  logic [3:0]    code_w;

  // Strict '>' keeps the first (lowest-index) bin on ties.
  always_comb begin
    rmax = mag_q[0];
    ri   = 2'd0;
    for (int unsigned i = 1; i < 4; i++) begin
      if (mag_q[i] > rmax) begin
        rmax = mag_q[i];
        ri   = 2'(i);
      end
    end
    cmax = mag_q[4];
    ci   = 2'd0;
    for (int unsigned i = 5; i < 8; i++) begin
      if (mag_q[i] > cmax) begin
        cmax = mag_q[i];
        ci   = 2'(i - 4);
      end
    end
  end

  // Widened by 8 bits so the min<<7 case cannot overflow.
  always_comb begin
    if (rmax >= cmax) begin
      hi_w    = {8'd0, rmax};
      lo_sh_w = {8'd0, cmax} << bus.twist_sh_i;
    end else begin
      hi_w    = {8'd0, cmax};
      lo_sh_w = {8'd0, rmax} << bus.twist_sh_i;
    end
    twist_ok = (hi_w <= lo_sh_w);
    det_w    = (rmax >= bus.thresh_i) && (cmax >= bus.thresh_i) && twist_ok;
    code_w   = {ri, ci};
  end

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    cap          = 1'b0;
    cand_d       = cand_q;
    cnt_d        = cnt_q;
    armed_d      = armed_q;
    key_code_d   = key_code_q;
    drop_d       = 1'b0;
    frame_done_d = 1'b0;
    det_d        = det_q;
    key_valid_d  = 1'b0;

    unique case (state_q)
      COLLECT: begin
        if (bus.flush) begin
          mask_d = '0;
          drop_d = bus.mag_valid;
        end else if (bus.mag_valid) begin
          cap    = 1'b1;
          mask_d = mask_q | (8'b1 << bus.mag_idx);
        end
        if (mask_d == '1) state_d = EVAL;
      end

      EVAL: begin
        drop_d       = bus.mag_valid;
        state_d      = REPORT;
        frame_done_d = 1'b1;
        det_d        = det_w;
        // Debounce is computed here so its registered result appears in REPORT
        // alongside frame_done.
        if (det_w) begin
          if (code_w == cand_q) begin
            cnt_d = (cnt_q >= DEB_C) ? DEB_C : cnt_q + 4'd1;
          end else begin
            cand_d  = code_w;
            cnt_d   = 4'd1;
            armed_d = 1'b1;
          end
        end else begin
          cnt_d   = '0;
          armed_d = 1'b1;
        end
        if (det_w && (cnt_d == DEB_C) && armed_d) begin
          key_valid_d = 1'b1;
          key_code_d  = cand_d;
          armed_d     = 1'b0;
        end
      end

      REPORT: begin
        drop_d  = bus.mag_valid;
        mask_d  = '0;
        state_d = COLLECT;
      end

      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= COLLECT;
      mask_q       <= '0;
      cand_q       <= '0;
      cnt_q        <= '0;
      armed_q      <= 1'b1;
      key_code_q   <= '0;
      drop_q       <= 1'b0;
      frame_done_q <= 1'b0;
      det_q        <= 1'b0;
      key_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      armed_q      <= armed_d;
      key_code_q   <= key_code_d;
      drop_q       <= drop_d;
      frame_done_q <= frame_done_d;
      det_q        <= det_d;
      key_valid_q  <= key_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cap) mag_q[bus.mag_idx] <= bus.mag_i;
  end

  assign bus.busy       = (state_q != COLLECT);
  assign bus.drop       = drop_q;
  assign bus.frame_done = frame_done_q;
  assign bus.det        = det_q;
  assign bus.key_valid  = key_valid_q;
  assign bus.key_code   = key_code_q;

endmodule

// File: tb/tb_goertzel_dtmf_decide.sv
// Directed bench for goertzel_dtmf_decide (DEB=2, MW=32).
module tb_goertzel_dtmf_decide;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_fail;
  int   fd_cnt;
  int   fd_mark;
  logic [31:0] frm [8];

  goertzel_dtmf_decide_if #(.MW(32)) bus ();

  goertzel_dtmf_decide #(.DEB(2), .MW(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.frame_done === 1'b1) fd_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int unsigned a, input logic [31:0] va,
                      input int unsigned b, input logic [31:0] vb);
    for (int i = 0; i < 8; i++) frm[i] = 32'd100;
    frm[a] = va;
    frm[b] = vb;
  endtask

  task automatic feed(input int unsigned idx);
    bus.mag_valid = 1'b1;
    bus.mag_idx   = 3'(idx);
    bus.mag_i     = frm[idx];
    tick();
    bus.mag_valid = 1'b0;
  endtask

  task automatic feed_frame();
    for (int unsigned i = 0; i < 8; i++) feed(i);
  endtask

  // Entered in cycle N+1 (first cycle after the capture edge).
  task automatic finish_frame(input string tag, input logic e_det,
                              input logic e_kv, input logic [3:0] e_code);
    check({tag, "_busy_n1"}, bus.busy, 1'b1);
    check({tag, "_fd_n1"}, bus.frame_done, 1'b0);
    tick();
    check({tag, "_fd_n2"}, bus.frame_done, 1'b1);
    check({tag, "_det"}, bus.det, e_det);
    check({tag, "_kv"}, bus.key_valid, e_kv);
    if (e_kv) check({tag, "_code"}, bus.key_code, e_code);
    tick();
    check({tag, "_fd_n3"}, bus.frame_done, 1'b0);
    check({tag, "_busy_n3"}, bus.busy, 1'b0);
  endtask

  task automatic frame(input string tag, input logic e_det,
                       input logic e_kv, input logic [3:0] e_code);
    feed_frame();
    finish_frame(tag, e_det, e_kv, e_code);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_drop"}, bus.drop, 1'b0);
    check({tag, "_fd"}, bus.frame_done, 1'b0);
    check({tag, "_det"}, bus.det, 1'b0);
    check({tag, "_kv"}, bus.key_valid, 1'b0);
    check({tag, "_code"}, bus.key_code, 4'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    fd_cnt   = 0;
    rstn     = 1'b0;
    bus.mag_valid  = 1'b0;
    bus.mag_idx    = '0;
    bus.mag_i      = '0;
    bus.thresh_i   = 32'd1000;
    bus.twist_sh_i = 3'd3;
    bus.flush      = 1'b0;
    repeat (3) tick();
    check_reset_outputs("rst");
    rstn = 1'b1;
    tick();

    // Tone row1/col6 -> code 6; debounce over several frames
    load(1, 32'd50000, 6, 32'd40000);
    frame("t1", 1'b1, 1'b0, 4'd0);
    frame("t2", 1'b1, 1'b1, 4'd6);
    frame("t3", 1'b1, 1'b0, 4'd0);
    frame("t4", 1'b1, 1'b0, 4'd0);
    load(0, 32'd100, 4, 32'd100);
    frame("gap", 1'b0, 1'b0, 4'd0);
    load(1, 32'd50000, 6, 32'd40000);
    frame("t5", 1'b1, 1'b0, 4'd0);
    frame("t6", 1'b1, 1'b1, 4'd6);

    // Twist: 80000 vs 5000<<3 fails, vs 5000<<4 passes
    load(0, 32'd80000, 4, 32'd5000);
    frame("tw3", 1'b0, 1'b0, 4'd0);
    bus.twist_sh_i = 3'd4;
    frame("tw4a", 1'b1, 1'b0, 4'd0);
    frame("tw4b", 1'b1, 1'b1, 4'd0);
    bus.twist_sh_i = 3'd3;

    // Threshold boundary and tie-break
    load(2, 32'd999, 5, 32'd1000);
    frame("th999", 1'b0, 1'b0, 4'd0);
    load(2, 32'd1000, 5, 32'd1000);
    frame("th1000", 1'b1, 1'b0, 4'd0);
    load(2, 32'd2000, 7, 32'd2000);
    frm[3] = 32'd2000;
    frame("tie1", 1'b1, 1'b0, 4'd0);
    frame("tie2", 1'b1, 1'b1, 4'd11);

    // mag_valid held through EVAL/REPORT is dropped
    load(1, 32'd50000, 6, 32'd40000);
    feed_frame();
    bus.mag_valid = 1'b1;
    bus.mag_idx   = 3'd0;
    bus.mag_i     = 32'd7;
    check("hold_busy", bus.busy, 1'b1);
    tick();
    check("hold_fd", bus.frame_done, 1'b1);
    check("hold_drop_eval", bus.drop, 1'b1);
    check("hold_det", bus.det, 1'b1);
    check("hold_kv", bus.key_valid, 1'b0);
    tick();
    check("hold_drop_rep", bus.drop, 1'b1);
    check("hold_busy_off", bus.busy, 1'b0);
    bus.mag_valid = 1'b0;
    tick();
    check("hold_drop_end", bus.drop, 1'b0);
    fd_mark = fd_cnt;
    for (int unsigned i = 1; i < 8; i++) feed(i);
    repeat (3) tick();
    check("hold_no_fd", 32'(fd_cnt - fd_mark), 32'd0);
    feed(0);
    finish_frame("hold_next", 1'b1, 1'b1, 4'd6);

    // flush with simultaneous sample on idx 5
    for (int unsigned i = 0; i < 5; i++) feed(i);
    bus.flush     = 1'b1;
    bus.mag_valid = 1'b1;
    bus.mag_idx   = 3'd5;
    bus.mag_i     = frm[5];
    tick();
    bus.flush     = 1'b0;
    bus.mag_valid = 1'b0;
    check("flush_drop", bus.drop, 1'b1);
    fd_mark = fd_cnt;
    for (int unsigned i = 0; i < 5; i++) feed(i);
    feed(6);
    feed(7);
    repeat (3) tick();
    check("flush_no_fd", 32'(fd_cnt - fd_mark), 32'd0);
    feed(5);
    finish_frame("flush_next", 1'b1, 1'b0, 4'd0);

    // Reset mid-frame: old samples and debounce state are lost
    load(0, 32'd90000, 4, 32'd90000);
    for (int unsigned i = 0; i < 5; i++) feed(i);
    #2;
    rstn = 1'b0;
    #2;
    check_reset_outputs("mid_rst");
    rstn = 1'b1;
    tick();
    fd_mark = fd_cnt;
    load(3, 32'd30000, 7, 32'd30000);
    feed(5);
    feed(6);
    feed(7);
    repeat (2) tick();
    check("rst_partial_no_fd", 32'(fd_cnt - fd_mark), 32'd0);
    for (int unsigned i = 0; i < 5; i++) feed(i);
    finish_frame("rst_new", 1'b1, 1'b0, 4'd0);
    repeat (4) tick();
    check("rst_one_fd", 32'(fd_cnt - fd_mark), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
